data_bridge_timer: RTL and testbench

- Sits directly downstream of the pipelined CPU's data-memory port (m_data_*), between the CPU and the data RAM.
- Decodes each CPU data access and routes it either to the external data RAM or to an internal count-down timer (TC0).
- Returns read data combinationally, in the same cycle as the address, which matches the CPU's M-stage sampling.
- Drives a timer interrupt request to the future exception/CP0 block.

---
 rtl/data_bridge_timer.sv | 115 +++++++++++
 tb/tb_data_bridge_timer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_bridge_timer.sv
// data_bridge_timer: routes CPU data accesses to data RAM or to the TC0 count-down timer
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   m_data_addr    CPU data byte address
//   m_data_wdata   CPU store data, lane-replicated
//   m_data_byteen  CPU byte write enables (0 = read / no access)
//   m_data_rdata   combinational read data to CPU
//   dm_addr        data RAM address (pass-through)
//   dm_wdata       data RAM write data (pass-through)
//   dm_byteen      data RAM byte enables, gated by the RAM window
//   dm_rdata       data RAM read data
//   irq            registered timer interrupt
module data_bridge_timer #(
    parameter logic [31:0] DM_LIMIT = 32'h0000_3000,
    parameter logic [31:0] TC_BASE  = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t      r_state, w_state_next;
    logic        r_en, r_im, r_flag, r_irq;
    logic [1:0]  r_mode;
    logic [31:0] r_preset, r_count;
    logic        w_en_next, w_im_next, w_flag_next;
    logic [1:0]  w_mode_next;
    logic [31:0] w_count_next, w_preset_wr, w_tc_rdata;
    logic [29:0] w_off;
    logic        w_ram_hit, w_tc_hit, w_wr_ctrl, w_wr_preset;
    logic [3:0]  w_ctrl_wr;
    // word offset into the timer window; wraps to a large value below the base
    assign w_off       = m_data_addr[31:2] - TC_BASE[31:2];
    assign w_ram_hit   = m_data_addr < DM_LIMIT;
    assign w_tc_hit    = w_off < 30'd3;
    assign w_wr_ctrl   = w_tc_hit && (|m_data_byteen) && w_off[1:0] == 2'd0;
    assign w_wr_preset = w_tc_hit && (|m_data_byteen) && w_off[1:0] == 2'd1;
    // only lane 0 carries implemented CTRL bits
    assign w_ctrl_wr   = m_data_byteen[0] ? m_data_wdata[3:0] : {r_im, r_mode, r_en};
    always_comb begin
        w_preset_wr = r_preset;
        for (int i = 0; i < 4; i++)
            w_preset_wr[8*i +: 8] = m_data_byteen[i] ? m_data_wdata[8*i +: 8] : r_preset[8*i +: 8];
    end
    assign w_tc_rdata   = w_off[1:0] == 2'd0 ? {28'd0, r_im, r_mode, r_en} :
                          w_off[1:0] == 2'd1 ? r_preset : r_count;
    assign m_data_rdata = w_ram_hit ? dm_rdata : w_tc_hit ? w_tc_rdata : 32'd0;
    assign dm_addr      = m_data_addr;
    assign dm_wdata     = m_data_wdata;
    assign dm_byteen    = w_ram_hit ? m_data_byteen : 4'd0;
    assign irq          = r_irq;
    always_comb begin
        w_state_next = r_state;
        w_en_next    = r_en;
        w_mode_next  = r_mode;
        w_im_next    = r_im;
        w_count_next = r_count;
        w_flag_next  = r_flag;
        case (r_state)
            IDLE: w_state_next = r_en ? LOAD : IDLE;
            LOAD: begin
                w_count_next = r_preset;
                w_state_next = CNT;
            end
            CNT: begin
                w_state_next = !r_en ? IDLE : r_count == 32'd0 ? INT : CNT;
                w_count_next = (r_en && r_count != 32'd0) ? r_count - 32'd1 : r_count;
            end
            INT: begin
                w_state_next = IDLE;
                w_flag_next  = r_mode == 2'b01 ? 1'b0 : r_flag;
                w_en_next    = r_mode == 2'b01 ? r_en : 1'b0;
            end
        endcase
        if (w_wr_ctrl || w_wr_preset)
            w_flag_next = 1'b0;
        // expiry beats a same-edge clear caused by a register write
        if (r_state == CNT && r_en && r_count == 32'd0)
            w_flag_next = 1'b1;
        // CPU write to CTRL beats the one-shot auto-disable
        if (w_wr_ctrl)
            {w_im_next, w_mode_next, w_en_next} = w_ctrl_wr;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_en     <= 1'b0;
            r_mode   <= 2'd0;
            r_im     <= 1'b0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_flag   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_en     <= w_en_next;
            r_mode   <= w_mode_next;
            r_im     <= w_im_next;
            r_preset <= w_wr_preset ? w_preset_wr : r_preset;
            r_count  <= w_count_next;
            r_flag   <= w_flag_next;
            // irq follows the next-state flag and mask so it lines up with the flag edge
            r_irq    <= w_flag_next & w_im_next;
        end
    end
endmodule

// File: tb/tb_data_bridge_timer.sv
// tb_data_bridge_timer: directed self-checking bench for data_bridge_timer
module tb_data_bridge_timer;
    localparam logic [31:0] A_CTRL = 32'h7F00, A_PRE = 32'h7F04, A_CNT = 32'h7F08;
    logic        clk = 1'b0, reset;
    logic [31:0] m_data_addr, m_data_wdata, m_data_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  m_data_byteen, dm_byteen;
    logic        irq;
    int          n_chk = 0, n_pass = 0;
    data_bridge_timer dut (
        .clk(clk), .reset(reset),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
        .m_data_rdata(m_data_rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_byteen(dm_byteen), .dm_rdata(dm_rdata), .irq(irq)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        cyc();
        m_data_byteen = 4'h0;
    endtask
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        m_data_addr   = a;
        m_data_byteen = 4'h0;
        #1;
        chk(tag, m_data_rdata, exp);
    endtask
    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask
    initial begin
        reset = 1'b0; m_data_addr = 0; m_data_wdata = 0; m_data_byteen = 0; dm_rdata = 32'hCAFE0000;
        #12;
        chk_irq("rst_irq", 1'b0);
        rd("rst_ctrl", A_CTRL, 32'd0);
        rd("rst_cnt", A_CNT, 32'd0);
        reset = 1'b1;
        cyc();
        // RAM pass-through
        m_data_addr = 32'h100; m_data_wdata = 32'hDEADBEEF; m_data_byteen = 4'hF; #1;
        chk("ram_wr_be", {28'd0, dm_byteen}, 32'hF);
        chk("ram_addr", dm_addr, 32'h100);
        chk("ram_wdata", dm_wdata, 32'hDEADBEEF);
        cyc();
        m_data_byteen = 4'h0; dm_rdata = 32'hDEADBEEF; #1;
        chk("ram_rd", m_data_rdata, 32'hDEADBEEF);
        cyc();
        m_data_addr = A_CTRL; m_data_wdata = 32'd0; m_data_byteen = 4'hF; #1;
        chk("tc_wr_be", {28'd0, dm_byteen}, 32'h0);
        cyc();
        m_data_addr = 32'h2FFC; #1;
        chk("edge_lo_be", {28'd0, dm_byteen}, 32'hF);
        m_data_addr = 32'h3000; #1;
        chk("edge_hi_be", {28'd0, dm_byteen}, 32'h0);
        m_data_byteen = 4'h0; dm_rdata = 32'h11111111;
        rd("edge_hi_rd", 32'h3000, 32'd0);
        rd("unmap_rd", 32'h8000, 32'd0);
        rd("tc_past_rd", 32'h7F0C, 32'd0);
        cyc();
        rd("edge_lo_rd", 32'h2FFC, 32'h11111111);
        cyc();
        // one-shot timing
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        cyc();
        cyc();
        rd("os_cnt5", A_CNT, 32'd5);
        for (int k = 4; k >= 0; k--) begin
            cyc();
            rd($sformatf("os_cnt%0d", k), A_CNT, k);
        end
        chk_irq("os_pre_irq", 1'b0);
        cyc();
        chk_irq("os_irq_e8", 1'b1);
        cyc();
        chk_irq("os_irq_e9", 1'b1);
        rd("os_ctrl", A_CTRL, 32'h8);
        cyc(); cyc(); cyc();
        chk_irq("os_sticky", 1'b1);
        rd("os_cnt_hold", A_CNT, 32'd0);
        wr(A_PRE, 32'd5, 4'hF);
        chk_irq("os_clr", 1'b0);
        // byte lanes and read-only COUNT
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_PRE, 32'hAABBCCDD, 4'b0100);
        rd("lane_pre", A_PRE, 32'h00BB0000);
        wr(A_CTRL, 32'hFFFFFFF0, 4'hF);
        rd("ctrl_hi0", A_CTRL, 32'd0);
        // masked interrupt
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk_irq($sformatf("mask_irq%0d", k), 1'b0);
        end
        rd("mask_ctrl", A_CTRL, 32'd0);
        // disable mid-count
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        cyc(); cyc(); cyc(); cyc();
        wr(A_CTRL, 32'h0, 4'hF);
        rd("dis_cnt2", A_CNT, 32'd2);
        cyc(); cyc(); cyc();
        rd("dis_hold", A_CNT, 32'd2);
        wr(A_CNT, 32'hFFFFFFFF, 4'hF);
        rd("cnt_ro", A_CNT, 32'd2);
        wr(A_CTRL, 32'h1, 4'hF);
        cyc();
        rd("restart_idle", A_CNT, 32'd2);
        cyc();
        rd("restart_load", A_CNT, 32'd5);
        wr(A_CTRL, 32'h0, 4'hF);
        cyc(); cyc();
        // auto-reload
        wr(A_PRE, 32'd2, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 18; k++) begin
            cyc();
            chk_irq($sformatf("ar_irq%0d", k), k == 5 || k == 11 || k == 17);
        end
        rd("ar_ctrl", A_CTRL, 32'hB);
        wr(A_CTRL, 32'h0, 4'hF);
        cyc(); cyc(); cyc();
        // PRESET=0, same-edge priorities
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        cyc(); cyc();
        chk_irq("z_pre_irq", 1'b0);
        cyc();
        chk_irq("z_irq", 1'b1);
        wr(A_CTRL, 32'h9, 4'hF);
        rd("cpu_wins", A_CTRL, 32'h9);
        chk_irq("wr_clears", 1'b0);
        cyc(); cyc();
        wr(A_PRE, 32'd0, 4'hF);
        chk_irq("set_wins", 1'b1);
        cyc();
        rd("z_ctrl", A_CTRL, 32'h8);
        chk_irq("z_sticky", 1'b1);
        // async reset while irq is high
        reset = 1'b0; #1;
        chk_irq("rst_irq_hi", 1'b0);
        rd("rst_ctrl_hi", A_CTRL, 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        // async reset mid-count
        wr(A_PRE, 32'd9, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        cyc(); cyc(); cyc(); cyc();
        rd("mid_cnt7", A_CNT, 32'd7);
        #2;
        reset = 1'b0;
        rd("arst_cnt", A_CNT, 32'd0);
        rd("arst_ctrl", A_CTRL, 32'd0);
        rd("arst_pre", A_PRE, 32'd0);
        cyc(); cyc();
        rd("arst_hold_cnt", A_CNT, 32'd0);
        rd("arst_hold_ctrl", A_CTRL, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        rd("post_cnt", A_CNT, 32'd0);
        chk_irq("post_irq", 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
